// File: rtl/svfloat_pkg.sv
// Floating-point types and sign-manipulation helpers shared by the svfloat blocks.
package svfloat;

  // IEEE-754 single precision, fields named so generic blocks can reach them.
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } float32;

  // Sign operations; encoding 2'b11 is reserved and behaves like SGN_PASS.
  typedef enum logic [1:0] {
    SGN_PASS = 2'b00,
    SGN_NEG  = 2'b01,
    SGN_ABS  = 2'b10
  } sgn_op_t;

  // Negator control bit for an op. ABS flips only negative operands, which
  // clears the sign unless the negator decides to preserve a NaN.
  function automatic logic sgn_neg_bit(input logic [1:0] op, input logic sign);
    logic neg;
    case (op)
      SGN_NEG: neg = 1'b1;
      SGN_ABS: neg = sign;
      default: neg = 1'b0;
    endcase
    return neg;
  endfunction

endpackage

// File: rtl/svfloat_neg.sv
// Conditional sign flip. NaNs keep their sign when presv_nan is set.
module svfloat_neg #(
  parameter type float = svfloat::float32
) (
  input  float val,
  input  logic neg,
  input  logic presv_nan,
  output float res
);

  logic is_nan;

  assign is_nan = (&val.exp) && (|val.man);

  // Flip the sign bit unless a NaN is being protected.
  always_comb begin
    res = val;
    if (!(presv_nan && is_nan)) begin
      res.sign = val.sign ^ neg;
    end
  end

endmodule

// File: rtl/svfloat_sgn_arbiter.sv
// Round-robin share of one svfloat_neg between N_REQ valid/ready requesters,
// with a single registered result slot that supports full throughput.
module svfloat_sgn_arbiter
  import svfloat::*;
#(
  parameter type float = svfloat::float32,
  parameter int  N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        presv_nan,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  float [N_REQ-1:0]            req_val,
  input  logic [N_REQ-1:0][1:0]       req_op,
  output logic                        res_valid,
  input  logic                        res_ready,
  output float                        res_val,
  output logic [ID_W-1:0]             res_id
);

  // Rotate so the pointer sits at bit 0, take the lowest set bit, then
  // rotate the index back. Result is {found, index}.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] v,
                                            input logic [ID_W-1:0]  ptr);
    logic [2*N_REQ-1:0] dbl;
    logic               found;
    int                 off;
    int                 idx;
    dbl   = {v, v} >> ptr;
    found = 1'b0;
    off   = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (dbl[i]) begin
        found = 1'b1;
        off   = i;
      end
    end
    idx = int'(ptr) + off;
    if (idx >= N_REQ) idx = idx - N_REQ;
    return {found, idx[ID_W-1:0]};
  endfunction

  logic              res_valid_reg;
  float              res_val_reg;
  logic [ID_W-1:0]   res_id_reg;
  logic [ID_W-1:0]   rr_ptr_reg;
  logic [ID_W-1:0]   rr_ptr_next;

  logic              can_accept;
  logic              gnt_found;
  logic [ID_W-1:0]   gnt_idx;
  logic              xfer;
  float              gnt_val;
  logic [1:0]        gnt_op;
  logic              gnt_neg;
  float              neg_res;

  assign {gnt_found, gnt_idx} = rr_pick(req_valid, rr_ptr_reg);
  assign can_accept           = !res_valid_reg || res_ready;
  // Grant is withheld during reset so nothing is consumed that would be dropped.
  assign xfer                 = gnt_found && can_accept && !rst;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready[gi] = xfer && (gnt_idx == ID_W'(gi));
    end
  endgenerate

  assign gnt_val     = req_val[gnt_idx];
  assign gnt_op      = req_op[gnt_idx];
  assign gnt_neg     = sgn_neg_bit(gnt_op, gnt_val.sign);
  assign rr_ptr_next = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  svfloat_neg #(.float(float)) u_neg (
    .val       (gnt_val),
    .neg       (gnt_neg),
    .presv_nan (presv_nan),
    .res       (neg_res)
  );

  // Result slot and round-robin pointer; payload holds its value on drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_reg <= 1'b0;
      res_val_reg   <= '0;
      res_id_reg    <= '0;
      rr_ptr_reg    <= '0;
    end else if (xfer) begin
      res_valid_reg <= 1'b1;
      res_val_reg   <= neg_res;
      res_id_reg    <= gnt_idx;
      rr_ptr_reg    <= rr_ptr_next;
    end else if (res_ready) begin
      res_valid_reg <= 1'b0;
    end
  end

  assign res_valid = res_valid_reg;
  assign res_val   = res_val_reg;
  assign res_id    = res_id_reg;

endmodule

// File: tb/tb_svfloat_sgn_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic, all
// compared each cycle against a behavioural model of the arbiter.
module tb_svfloat_sgn_arbiter;

  localparam int N = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  presv_nan;
  logic [N-1:0]          req_valid;
  logic [N-1:0]          req_ready;
  svfloat::float32 [N-1:0] req_val;
  logic [N-1:0][1:0]     req_op;
  logic                  res_valid;
  logic                  res_ready;
  svfloat::float32       res_val;
  logic [1:0]            res_id;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  bit          m_valid;
  logic [31:0] m_val;
  int          m_id;
  int          m_ptr;
  bit          last_xfer;
  int          last_g;

  svfloat_sgn_arbiter #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .presv_nan (presv_nan),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_val   (req_val),
    .req_op    (req_op),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_val   (res_val),
    .res_id    (res_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected result of an op on a float32 bit pattern.
  function automatic logic [31:0] model_res(input logic [1:0] op, input logic [31:0] v,
                                            input logic pn);
    bit is_nan;
    is_nan = (v[30:23] == 8'hFF) && (v[22:0] != 0);
    if (pn && is_nan) return v;
    case (op)
      2'd1:    return {~v[31], v[30:0]};
      2'd2:    return {1'b0, v[30:0]};
      default: return v;
    endcase
  endfunction

  function automatic logic [31:0] rand_float();
    case ($urandom_range(0, 5))
      0:       return {1'($urandom), 31'h7FC00000};
      1:       return {1'($urandom), 8'hFF, 23'h0};
      2:       return {1'($urandom), 31'h0};
      3:       return {1'($urandom), 8'hFF, 23'($urandom_range(1, 1000))};
      default: return $urandom;
    endcase
  endfunction

  // One clock cycle: check req_ready mid-cycle, advance model, check outputs.
  task automatic step();
    logic [N-1:0] exp_rdy;
    int g;
    bit can;
    int i;
    @(negedge clk);
    exp_rdy = '0;
    g = -1;
    can = !m_valid || res_ready;
    if (!rst && can) begin
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (req_valid[i] && g < 0) g = i;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    last_xfer = (g >= 0);
    last_g    = (g >= 0) ? g : 0;
    if (rst) begin
      m_valid = 0; m_val = '0; m_id = 0; m_ptr = 0;
    end else if (g >= 0) begin
      m_val   = model_res(req_op[g], req_val[g], presv_nan);
      m_id    = g;
      m_valid = 1;
      m_ptr   = (g + 1) % N;
    end else if (res_ready) begin
      m_valid = 0;
    end
    #1;
    check("res_valid", 32'(res_valid), 32'(m_valid));
    check("res_val", res_val, m_val);
    check("res_id", 32'(res_id), 32'(m_id));
    if (last_xfer)
      $display("xfer id=%0d op=%0d in=%h pn=%0d -> res=%h", g, req_op[g], req_val[g],
               presv_nan, res_val);
  endtask

  typedef struct { logic [1:0] op; logic [31:0] v; logic pn; logic [31:0] exp; } op_case_t;
  op_case_t op_cases[6];

  initial begin
    op_cases[0] = '{2'd1, 32'h3F800000, 1'b0, 32'hBF800000};
    op_cases[1] = '{2'd2, 32'hC0000000, 1'b0, 32'h40000000};
    op_cases[2] = '{2'd0, 32'h80000000, 1'b0, 32'h80000000};
    op_cases[3] = '{2'd1, 32'h7FC00000, 1'b1, 32'h7FC00000};
    op_cases[4] = '{2'd1, 32'h7FC00000, 1'b0, 32'hFFC00000};
    op_cases[5] = '{2'd2, 32'hFFC00000, 1'b1, 32'hFFC00000};

    rst = 1'b1; presv_nan = 1'b0; res_ready = 1'b1;
    req_valid = '1; req_op = '0;
    for (int i = 0; i < N; i++) req_val[i] = 32'h1000_0000 * (i + 1);

    // 1. Reset with everyone requesting, then first grant goes to 0
    step(); step();
    check("t1_rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    step();
    check("t1_first_id", 32'(res_id), 32'd0);
    req_valid = '0;
    step();

    // 2/3. Op mapping and NaN handling on requester 0
    for (int c = 0; c < 6; c++) begin
      req_valid  = 4'b0001;
      req_op[0]  = op_cases[c].op;
      req_val[0] = op_cases[c].v;
      presv_nan  = op_cases[c].pn;
      step();
      check($sformatf("op_case%0d", c), res_val, op_cases[c].exp);
      check($sformatf("op_id%0d", c), 32'(res_id), 32'd0);
    end
    req_valid = '0; presv_nan = 1'b0;

    // 4. Fairness from a fresh pointer, one result per cycle
    rst = 1'b1; step(); rst = 1'b0;
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      step();
      check("fair_id", 32'(res_id), 32'(c % N));
      check("fair_valid", 32'(res_valid), 32'd1);
    end

    // 5. Backpressure holds the slot; release accepts req1 immediately
    req_valid = 4'b0010; res_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_hold_id", 32'(res_id), 32'd3);
      check("bp_hold_valid", 32'(res_valid), 32'd1);
    end
    res_ready = 1'b1;
    step();
    check("bp_release_id", 32'(res_id), 32'd1);

    // 6. Reset mid-stream drops the result; grant restarts at 0
    res_ready = 1'b0; req_valid = 4'b0100; rst = 1'b1;
    step();
    check("t6_dropped", 32'(res_valid), 32'd0);
    rst = 1'b0; res_ready = 1'b1; req_valid = '1;
    step();
    check("t6_restart_id", 32'(res_id), 32'd0);

    // Randomized traffic; requesters hold their operand until accepted
    req_valid = '0;
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 49) == 0);
      res_ready = ($urandom_range(0, 3) != 0);
      presv_nan = 1'($urandom);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          req_valid[i] = 1'b1;
          req_val[i]   = rand_float();
          req_op[i]    = 2'($urandom_range(0, 3));
        end
      end
      step();
      if (last_xfer) begin
        req_valid[last_g] = 1'($urandom);
        req_val[last_g]   = rand_float();
        req_op[last_g]    = 2'($urandom_range(0, 3));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
